onehot_hdlc_detector: RTL and testbench

- Parametrised successor to the team's fixed 10-state one-hot HDLC bit-stream FSM.
- Serial-bit monitor for bit-stuffed links. Detects three events:
  - discard: a stuffed zero after RUN_LEN ones;
  - flag: a zero after RUN_LEN+1 ones;
  - error: RUN_LEN+2 or more consecutive ones.
- Adds a qualifying valid, a configurable run length, illegal-state recovery and optional event statistics.
- Sits between the line deserialiser and the frame delineation logic.

---
 rtl/onehot_hdlc_detector.sv | 111 +++++++++++
 tb/tb_onehot_hdlc_detector.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_hdlc_detector.sv
// One-hot HDLC bit-stream monitor: flags stuffed zeros, flag sequences and abort runs.
// Optional event statistics are built when ONEHOT_HDLC_STATS_EN is defined.
module onehot_hdlc_detector #(
   parameter int RUN_LEN = 5,
   parameter int CNT_W   = 8,
   localparam int STATE_W = RUN_LEN + 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in,
   output logic [STATE_W-1:0] state,
   output logic               disc,
   output logic               flag,
   output logic               err,
   input  logic               stats_clr,
   output logic [CNT_W-1:0]   disc_cnt,
   output logic [CNT_W-1:0]   flag_cnt,
   output logic [CNT_W-1:0]   err_cnt
);

   localparam int ERR_B  = RUN_LEN + 2;
   localparam int DISC_B = RUN_LEN + 3;
   localparam int FLAG_B = RUN_LEN + 4;
   localparam logic [STATE_W-1:0] S0 = STATE_W'(1);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic               legal;

   // A state is legal only if exactly one bit is set.
   assign legal = (state_q != '0) && ((state_q & (state_q - S0)) == '0);

   always_comb begin
      state_d = state_q;
      if (!legal) begin
         state_d = S0;
      end else if (in_valid) begin
         state_d            = '0;
         state_d[0]         = ~in & (|state_q[RUN_LEN-1:0] | state_q[ERR_B]
                                     | state_q[DISC_B] | state_q[FLAG_B]);
         state_d[1]         = in & (state_q[0] | state_q[DISC_B] | state_q[FLAG_B]);
         for (int k = 2; k <= RUN_LEN + 1; k++) begin
            state_d[k] = in & state_q[k-1];
         end
         state_d[ERR_B]     = in & (state_q[RUN_LEN+1] | state_q[ERR_B]);
         state_d[DISC_B]    = ~in & state_q[RUN_LEN];
         state_d[FLAG_B]    = ~in & state_q[RUN_LEN+1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;
   assign disc  = legal & state_q[DISC_B];
   assign flag  = legal & state_q[FLAG_B];
   assign err   = legal & state_q[ERR_B];

`ifdef ONEHOT_HDLC_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0]       enter;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];

   // Counters step on state entry only, so a long abort run counts once.
   always_comb begin
      enter = {state_d[ERR_B]  & ~state_q[ERR_B],
               state_d[FLAG_B] & ~state_q[FLAG_B],
               state_d[DISC_B] & ~state_q[DISC_B]};
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (stats_clr) begin
            cnt_d[i] = '0;
         end else if (enter[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign disc_cnt = cnt_q[0];
   assign flag_cnt = cnt_q[1];
   assign err_cnt  = cnt_q[2];
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;

   assign disc_cnt = '0;
   assign flag_cnt = '0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_onehot_hdlc_detector.sv
// Scoreboard bench for onehot_hdlc_detector with RUN_LEN=5/CNT_W=8 and RUN_LEN=3/CNT_W=2 instances.
module tb_onehot_hdlc_detector;

`ifdef ONEHOT_HDLC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      int          id;
      logic [36:0] v;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in5 = 1'b0, v5 = 1'b0, clr5 = 1'b0;
   logic in3 = 1'b0, v3 = 1'b0, clr3 = 1'b0;

   logic [9:0] st5;
   logic       d5, f5, e5;
   logic [7:0] dc5, fc5, ec5;
   logic [7:0] st3;
   logic       d3, f3, e3;
   logic [1:0] dc3, fc3, ec3;

   int vectors     = 0;
   int miscompares = 0;

   int RL   [2] = '{5, 3};
   int MAXC [2] = '{255, 3};
   int ones [2];
   int code [2];
   int cnt  [2][3];
   sb_t sb [$];

   always #5 clk = ~clk;

   onehot_hdlc_detector #(.RUN_LEN(5), .CNT_W(8)) dut5 (
      .clk(clk), .rst(rst), .in_valid(v5), .in(in5), .state(st5),
      .disc(d5), .flag(f5), .err(e5), .stats_clr(clr5),
      .disc_cnt(dc5), .flag_cnt(fc5), .err_cnt(ec5));

   onehot_hdlc_detector #(.RUN_LEN(3), .CNT_W(2)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in(in3), .state(st3),
      .disc(d3), .flag(f3), .err(e3), .stats_clr(clr3),
      .disc_cnt(dc3), .flag_cnt(fc3), .err_cnt(ec3));

   // Reference: state code from the length of the current run of ones.
   function automatic int model_code(input int run, input logic b, input int r);
      if (b) return (run + 1 <= r + 1) ? run + 1 : r + 2;
      if (run == r) return r + 3;
      if (run == r + 1) return r + 4;
      return 0;
   endfunction

   function automatic logic [36:0] exp_vec(input int id);
      logic [9:0] s;
      logic       d, f, e;
      int         r;
      r = RL[id];
      s = '0;
      s[code[id]] = 1'b1;
      d = (code[id] == r + 3);
      f = (code[id] == r + 4);
      e = (code[id] == r + 2);
      if (id == 0)
         return {s, d, f, e, 8'(cnt[0][0]), 8'(cnt[0][1]), 8'(cnt[0][2])};
      return {20'd0, s[7:0], d, f, e, 2'(cnt[1][0]), 2'(cnt[1][1]), 2'(cnt[1][2])};
   endfunction

   function automatic logic [36:0] obs_vec(input int id);
      if (id == 0) return {st5, d5, f5, e5, dc5, fc5, ec5};
      return {20'd0, st3, d3, f3, e3, dc3, fc3, ec3};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         ones[i] = 0;
         code[i] = 0;
         for (int k = 0; k < 3; k++) cnt[i][k] = 0;
      end
   endtask

   // Drives one bit into the selected instance and pushes the expected result.
   task automatic drive(input int id, input logic b, input logic v, input logic clr);
      sb_t e;
      int  r, nc, ev;
      @(negedge clk);
      in5 = (id == 0) ? b : 1'b0;
      v5 = (id == 0) && v;
      clr5 = (id == 0) && clr;
      in3 = (id == 1) ? b : 1'b0;
      v3 = (id == 1) && v;
      clr3 = (id == 1) && clr;
      r = RL[id];
      if (code[id] < 0) begin
         nc = 0;
         ones[id] = 0;
      end else if (v) begin
         nc = model_code(ones[id], b, r);
         ones[id] = b ? ones[id] + 1 : 0;
      end else begin
         nc = code[id];
      end
      for (int k = 0; k < 3; k++) begin
         ev = (k == 0) ? r + 3 : (k == 1) ? r + 4 : r + 2;
         if (clr) cnt[id][k] = 0;
         else if (STATS && nc == ev && code[id] != ev && cnt[id][k] < MAXC[id]) cnt[id][k]++;
      end
      code[id] = nc;
      e.id = id;
      e.v  = exp_vec(id);
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sb_t         e;
      logic [36:0] o;
      logic        seq[$] = '{1'b0, 1'b1, 1'b1, 1'b1};
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      for (int id = 0; id < 2; id++) begin
         e.id = id;
         e.v  = exp_vec(id);
         sb.push_back(e);
         e = sb.pop_front();
         o = obs_vec(e.id);
         vectors++;
         if (o !== e.v) begin
            miscompares++;
            $display("[TB] FAIL reset_state id%0d: got %h expected %h", id, o, e.v);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      foreach (seq[i]) begin
         drive(0, seq[i], 1'b1, 1'b0);
         e = sb.pop_front();
         o = obs_vec(e.id);
         vectors++;
         if (o !== e.v) begin
            miscompares++;
            $display("[TB] FAIL reset_prerun step %0d: got %h expected %h", i, o, e.v);
         end
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      vectors++;
      if (st5 !== 10'b0000000001 || {d5, f5, e5} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_async: got state %b evts %b expected 0000000001/000", st5, {d5, f5, e5});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_discard();
      sb_t         e;
      logic [36:0] o;
      logic        seq[$] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      foreach (seq[i]) begin
         drive(0, seq[i], 1'b1, 1'b0);
         e = sb.pop_front();
         o = obs_vec(e.id);
         vectors++;
         if (o !== e.v) begin
            miscompares++;
            $display("[TB] FAIL discard step %0d: got %h expected %h", i, o, e.v);
         end
         if (i == 6) begin
            vectors++;
            if (st5 !== 10'b0100000000 || d5 !== 1'b1 || dc5 !== (STATS ? 8'd1 : 8'd0)) begin
               miscompares++;
               $display("[TB] FAIL discard_disc: got state %b disc %b cnt %0d", st5, d5, dc5);
            end
         end
      end
      vectors++;
      if (st5 !== 10'b0000000010 || d5 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL discard_s1: got %b expected 0000000010", st5);
      end
   endtask

   task automatic test_flag_error();
      sb_t         e;
      logic [36:0] o;
      logic        seq[$] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      foreach (seq[i]) begin
         drive(0, seq[i], 1'b1, 1'b0);
         e = sb.pop_front();
         o = obs_vec(e.id);
         vectors++;
         if (o !== e.v) begin
            miscompares++;
            $display("[TB] FAIL flag_error step %0d: got %h expected %h", i, o, e.v);
         end
         if (i == 7) begin
            vectors++;
            if (f5 !== 1'b1 || st5[9] !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL flag_seen: got state %b expected 1000000000", st5);
            end
         end
         if (i == 18) begin
            vectors++;
            if (e5 !== 1'b1 || ec5 !== (STATS ? 8'd1 : 8'd0)) begin
               miscompares++;
               $display("[TB] FAIL err_held: got err %b cnt %0d", e5, ec5);
            end
         end
      end
   endtask

   task automatic test_valid_gating();
      sb_t         e;
      logic [36:0] o;
      logic        seqb[$] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        seqv[$] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      foreach (seqb[i]) begin
         drive(0, seqb[i], seqv[i], 1'b0);
         e = sb.pop_front();
         o = obs_vec(e.id);
         vectors++;
         if (o !== e.v) begin
            miscompares++;
            $display("[TB] FAIL valid_gating step %0d: got %h expected %h", i, o, e.v);
         end
      end
      vectors++;
      if (d5 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL valid_gating_disc: got disc %b expected 1", d5);
      end
   endtask

   task automatic test_run_len3();
      sb_t         e;
      logic [36:0] o;
      logic        seq[$] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      foreach (seq[i]) begin
         drive(1, seq[i], 1'b1, 1'b0);
         e = sb.pop_front();
         o = obs_vec(e.id);
         vectors++;
         if (o !== e.v) begin
            miscompares++;
            $display("[TB] FAIL run_len3 step %0d: got %h expected %h", i, o, e.v);
         end
         if (i == 3 || i == 8 || i == 13) begin
            vectors++;
            if (st3 !== ((i == 3) ? 8'b01000000 : (i == 8) ? 8'b10000000 : 8'b00100000)) begin
               miscompares++;
               $display("[TB] FAIL run_len3_event step %0d: got %b", i, st3);
            end
         end
      end
      @(negedge clk);
      v3 = 1'b0;
      v5 = 1'b0;
      force dut3.state_q = 8'b00000011;
      #1;
      release dut3.state_q;
      #1;
      vectors++;
      if ({st3, d3, f3, e3} !== {8'b00000011, 3'b000}) begin
         miscompares++;
         $display("[TB] FAIL illegal_hold: got %b expected 00000011000", {st3, d3, f3, e3});
      end
      code[1] = -1;
      drive(1, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      o = obs_vec(e.id);
      vectors++;
      if (o !== e.v || st3 !== 8'b00000001) begin
         miscompares++;
         $display("[TB] FAIL illegal_recover: got %h expected %h", o, e.v);
      end
   endtask

   task automatic test_stats();
      sb_t         e;
      logic [36:0] o;
      for (int n = 0; n < 6; n++) begin
         for (int j = 0; j < 5; j++) begin
            drive(1, (j < 4) ? 1'b1 : 1'b0, 1'b1, (n == 5 && j == 4) ? 1'b1 : 1'b0);
            e = sb.pop_front();
            o = obs_vec(e.id);
            vectors++;
            if (o !== e.v) begin
               miscompares++;
               $display("[TB] FAIL stats flag %0d bit %0d: got %h expected %h", n, j, o, e.v);
            end
         end
         if (n == 4) begin
            vectors++;
            if (fc3 !== (STATS ? 2'd3 : 2'd0)) begin
               miscompares++;
               $display("[TB] FAIL stats_saturate: got %0d expected %0d", fc3, STATS ? 3 : 0);
            end
         end
      end
      vectors++;
      if (fc3 !== 2'd0 || f3 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stats_clr_priority: got cnt %0d flag %b expected 0/1", fc3, f3);
      end
   endtask

   task automatic test_back_to_back();
      sb_t         e;
      logic [36:0] o;
      for (int i = 0; i < 300; i++) begin
         drive(i % 2, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
         e = sb.pop_front();
         o = obs_vec(e.id);
         vectors++;
         if (o !== e.v) begin
            miscompares++;
            $display("[TB] FAIL back_to_back step %0d id%0d: got %h expected %h", i, e.id, o, e.v);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_discard();
      test_flag_error();
      test_valid_gating();
      test_run_len3();
      test_stats();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
